pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/adder_pkg.sv | 20 ++
 rtl/adder_chunk.sv | 35 +++
 rtl/pipelined_adder.sv | 124 ++++++++++++
 tb/tb_pipelined_adder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// ============================================================================
// adder_pkg : default sizing and slice-width helper for pipelined_adder
// Revision  : 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  // Returns 0 for an illegal split so the instantiating block can reject it.
  function automatic int chunk_width(input int width, input int stages);
    if (stages < 1 || (width % stages) != 0) return 0;
    return width / stages;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_chunk.sv
// ============================================================================
// adder_chunk : combinational W-bit ripple slice, also exposing carry into MSB
// Revision    : 1.0
// ============================================================================
`default_nettype none

module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         msb_ci
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co     = c[W];
  assign msb_ci = c[W-1];

endmodule

`default_nettype wire

// File: rtl/pipelined_adder.sv
// ============================================================================
// pipelined_adder : STAGES-deep carry-pipelined adder with valid/ready flow
//                   control; define ADDER_OVF_EN to add the signed ovf output.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (CHUNK < 1 || CHUNK * STAGES != WIDTH) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  // acc_q[k]: sum chunks 0..k completed, upper chunks still hold operand A.
  logic [WIDTH-1:0] acc_q   [STAGES];
  logic [WIDTH-1:0] bop_q   [STAGES];
  logic             carry_q [STAGES];
  logic             valid_q [STAGES];
  logic             stall;

`ifdef ADDER_OVF_EN
  logic             msbc_w  [STAGES];
  logic             msbc_q;
`endif

  assign stall     = valid_q[STAGES-1] && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = valid_q[STAGES-1];
  assign sum       = acc_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] src_acc;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] nxt_acc;
    logic             src_c;
    logic             src_v;
    logic [CHUNK-1:0] s_w;
    logic             co_w;

    if (k == 0) begin : g_first
      assign src_acc = a;
      assign src_b   = b;
      assign src_c   = cin;
      assign src_v   = in_valid;
    end else begin : g_next
      assign src_acc = acc_q[k-1];
      assign src_b   = bop_q[k-1];
      assign src_c   = carry_q[k-1];
      assign src_v   = valid_q[k-1];
    end

    adder_chunk #(.W(CHUNK)) u_chunk (
      .a      (src_acc[k*CHUNK +: CHUNK]),
      .b      (src_b[k*CHUNK +: CHUNK]),
      .ci     (src_c),
      .s      (s_w),
      .co     (co_w),
`ifdef ADDER_OVF_EN
      .msb_ci (msbc_w[k])
`else
      .msb_ci ()
`endif
    );

    always_comb begin
      nxt_acc                    = src_acc;
      nxt_acc[k*CHUNK +: CHUNK]  = s_w;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        acc_q[k]   <= '0;
        bop_q[k]   <= '0;
      end else if (!stall) begin
        valid_q[k] <= src_v;
        carry_q[k] <= co_w;
        acc_q[k]   <= nxt_acc;
        bop_q[k]   <= src_b;
      end
    end
  end

`ifdef ADDER_OVF_EN
  // Only the last slice holds the MSB, so only its carry-in is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msbc_q <= 1'b0;
    end else if (!stall) begin
      msbc_q <= msbc_w[STAGES-1];
    end
  end

  assign ovf = msbc_q ^ carry_q[STAGES-1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder.sv
// ============================================================================
// tb_pipelined_adder : scoreboard bench for pipelined_adder (32 bits, 4 stages)
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
`ifdef ADDER_OVF_EN
  logic        ovf;
`endif

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          checks    = 0;
  int          failures  = 0;
  int          cyc       = 0;
  bit          track_lat = 1'b0;
  bit          held_v    = 1'b0;
  logic [32:0] held_val;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model: plain wide arithmetic on every accepted operand set.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_t e;
      {e.c, e.s} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      e.o        = (a[31] == b[31]) && (e.s[31] != a[31]);
      e.due      = track_lat ? cyc + 4 : -1;
      sb.push_back(e);
    end
  end

  // Monitor: compares each transferred result and watches stall behaviour.
  always @(negedge clk) begin
    if (out_valid) begin
      if (held_v) check("hold_stable", {31'd0, cout, sum}, {31'd0, held_val});
      if (out_ready) begin
        held_v = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sum", {32'd0, sum}, {32'd0, e.s});
          check("cout", {63'd0, cout}, {63'd0, e.c});
`ifdef ADDER_OVF_EN
          check("ovf", {63'd0, ovf}, {63'd0, e.o});
`endif
          if (e.due >= 0) check("latency_cycle", 64'(cyc), 64'(e.due));
        end
      end else begin
        check("in_ready_stalled", {63'd0, in_ready}, 64'd0);
        held_val = {cout, sum};
        held_v   = 1'b1;
      end
    end else begin
      held_v = 1'b0;
      check("in_ready_idle", {63'd0, in_ready}, 64'd1);
    end
  end

  task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic cv);
    bit acc;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = cv;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_sum", {32'd0, sum}, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
`ifdef ADDER_OVF_EN
    check("rst_ovf", {63'd0, ovf}, 64'd0);
`endif
  endtask

  initial begin
    bit acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    // Full ripple, signed overflow corners, then eight back-to-back adds.
    track_lat = 1'b1;
    drive(32'hFFFF_FFFF, 32'h0, 1'b1);
    idle(5);
    drive(32'h7FFF_FFFF, 32'h1, 1'b0);
    drive(32'h8000_0000, 32'h8000_0000, 1'b0);
    idle(5);
    for (int i = 1; i <= 8; i++) drive(32'(i), 32'(i), 1'b0);
    idle(6);
    track_lat = 1'b0;

    // Five cycles of backpressure in the middle of a stream.
    fork
      for (int i = 0; i < 12; i++) drive($urandom, $urandom, 1'($urandom));
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(6);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) drive(32'h100 + 32'(i), 32'h10, 1'b1);
    rst = 1'b1;
    sb.delete();
    #1;
    check_reset_outputs();
    idle(2);
    rst = 1'b0;
    idle(8);

    // Randomised traffic; offered operands are held until accepted.
    in_valid = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(3) != 0);
        a        = $urandom;
        b        = $urandom;
        cin      = 1'($urandom);
        if ($urandom_range(7) == 0) a = 32'hFFFF_FFFF;
      end
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 50 && sb.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("drain_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
